// File: rtl/memory_access_module.sv
// Memory stage: EX/MEM register, word-addressed data memory, branch resolution
// and the MEM/WB register feeding writeback.
module memory_access_module #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic [31:0] add_result,
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data2_out,
    input  logic [4:0]  mux_out,
    input  logic        zero_out,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    output logic [31:0] branch_target,
    output logic        PCSrc,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [4:0]  write_reg_wb,
    output logic        MemtoReg_wb,
    output logic        RegWrite_wb
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] add_q, alu_q, data_q;
    logic [4:0]  wreg_q;
    logic        zero_q, m2r_q, rw_q, mr_q, mw_q, br_q;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            add_q  <= '0;
            alu_q  <= '0;
            data_q <= '0;
            wreg_q <= '0;
            zero_q <= 1'b0;
            m2r_q  <= 1'b0;
            rw_q   <= 1'b0;
            mr_q   <= 1'b0;
            mw_q   <= 1'b0;
            br_q   <= 1'b0;
        end else if (!mem_stall) begin
            add_q  <= add_result;
            alu_q  <= alu_result;
            data_q <= read_data2_out;
            wreg_q <= mux_out;
            zero_q <= zero_out;
            m2r_q  <= MemtoReg_in;
            rw_q   <= RegWrite_in;
            mr_q   <= MemRead_in;
            mw_q   <= MemWrite_in;
            br_q   <= Branch_in;
        end
    end

    // Byte address -> word index; low two bits and bits above the array are dropped.
    always_comb begin
        idx     = alu_q[ADDR_W+1:2];
        rd_data = '0;
        if (mr_q) rd_data = mem[idx];
    end

    // No reset on the array: contents survive rst, only the write is blocked.
    always_ff @(posedge clk) begin
        if (!rst && !mem_stall && mw_q) mem[idx] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_wb  <= '0;
            alu_result_wb <= '0;
            write_reg_wb  <= '0;
            MemtoReg_wb   <= 1'b0;
            RegWrite_wb   <= 1'b0;
        end else if (!mem_stall) begin
            read_data_wb  <= rd_data;
            alu_result_wb <= alu_q;
            write_reg_wb  <= wreg_q;
            MemtoReg_wb   <= m2r_q;
            RegWrite_wb   <= rw_q;
        end
    end

    always_comb begin
        PCSrc         = br_q & zero_q;
        branch_target = add_q;
    end

endmodule

// File: doc/memory_access_module.md
Name: memory_access_module

Overview:
Consumer side of the execution stage interface. It contains the EX/MEM pipeline register and a word-addressed data memory, resolves the branch decision, and drives the MEM/WB pipeline register toward writeback. It latches every execution-stage result and control bit, performs loads and stores, and presents registered writeback data plus the combinational PC-select and branch target to fetch.

Parameters:
ADDR_W, 8, data memory word-address width (depth = 2^ADDR_W words of 32 bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
mem_stall  input  1  hold both pipeline registers and suppress the memory write
add_result  input  32  branch target from execution stage
alu_result  input  32  ALU result / memory byte address
read_data2_out  input  32  store data
mux_out  input  5  destination register number
zero_out  input  1  ALU zero flag
MemtoReg_in  input  1  writeback select control
RegWrite_in  input  1  register write enable control
MemRead_in  input  1  load control
MemWrite_in  input  1  store control
Branch_in  input  1  branch instruction control
branch_target  output  32  latched add_result
PCSrc  output  1  branch taken to fetch (combinational)
read_data_wb  output  32  MEM/WB load data
alu_result_wb  output  32  MEM/WB ALU result
write_reg_wb  output  5  MEM/WB destination register
MemtoReg_wb  output  1  MEM/WB writeback select
RegWrite_wb  output  1  MEM/WB register write enable

Behaviour:
- EX/MEM register (all inputs): loads on every rising edge when rst=0 and mem_stall=0; holds when mem_stall=1. Reset value 0 for all fields.
- PCSrc = Branch_q & zero_q, where both are EX/MEM fields. branch_target = add_q. Both are valid in the cycle after EX presents them. Reset: PCSrc=0, branch_target=0.
- Memory index = alu_q[ADDR_W+1:2]. Bits [1:0] are ignored (no misalignment trap). Address bits above ADDR_W+1 are ignored, so addresses wrap modulo depth.
- Read: combinational from the array at the index when MemRead_q=1. When MemRead_q=0, the MEM/WB read_data field loads 0.
- Write: at a rising edge when MemWrite_q=1 and mem_stall=0 and rst=0, write data_q at the index.
- MemRead_q and MemWrite_q both 1: the read returns the pre-write (old) value, and the write still occurs.
- Back-to-back store then load to the same address: the load, one cycle later, returns the new data.
- Memory array contents are not cleared by rst; contents are undefined until written.
- MEM/WB register: loads {read data, alu_q, wreg_q, MemtoReg_q, RegWrite_q} on the same enable as EX/MEM. Reset value 0. Outputs are taken directly from these registers.
- Latency: EX values at edge k reach the MEM/WB outputs after edge k+1 (2 edges). PCSrc is visible after edge k.
- Stall: both registers hold, the write is suppressed, and PCSrc and branch_target stay stable.
- Priority: rst over mem_stall over normal load. A reset mid-store suppresses that write and zeroes both pipeline registers. The next cycle behaves as a bubble (RegWrite_wb=0, PCSrc=0).
- No handshake beyond mem_stall. Hazard detection and flushing are performed upstream.

Test Plan:
1. Reset: assert rst 2 cycles with all inputs nonzero -> every output is 0, PCSrc=0. Deassert -> the first latched instruction appears per the latency above.
2. Store then load: SW with alu_result=0x10, data=0xDEADBEEF; next cycle LW with alu_result=0x10, mux_out=5, MemtoReg=1, RegWrite=1 -> two edges later read_data_wb=0xDEADBEEF, write_reg_wb=5, RegWrite_wb=1.
3. Wrap and alignment: store 0x12345678 at alu_result=0x0000_0013; load alu_result=0x0000_0410 (ADDR_W=8) -> returns 0x12345678.
4. Branch: Branch_in=1, zero_out=1, add_result=0x40 -> next cycle PCSrc=1, branch_target=0x40. With zero_out=0 -> PCSrc=0.
5. Stall: during a store, hold mem_stall=1 for 3 cycles -> memory is unchanged (a later load returns the old value) and outputs are frozen. Release -> the store completes once.
6. Simultaneous: MemRead_q=MemWrite_q=1 at an address holding 0xAAAA_AAAA, writing 0x5555_5555 -> read_data_wb=0xAAAA_AAAA, and a subsequent load returns 0x5555_5555. Also: rst asserted coincident with a store -> the location is unchanged.
